// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: requester source tags and fixed access sizes.
package mem_arb_pkg;

  typedef enum logic [1:0] {SRC_NONE, SRC_IF, SRC_LS} arb_src_t;

  typedef struct packed {
    logic     valid;
    arb_src_t src;
  } arb_tag_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/LS) handshakes plus the memory-side port of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [2:0]        ls_funct3;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_funct3;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_funct3, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_addr, mem_funct3, mem_wren, mem_wdata, busy
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_funct3, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_addr, mem_funct3, mem_wren, mem_wdata, busy
  );
endinterface

// File: rtl/arb_resp_pipe.sv
// Read-response tag pipe: a tag entering now emerges DEPTH cycles later, matching memory latency.
// Never stalls; reset drops every in-flight tag.
module arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out,
  output logic     any_valid
);

  arb_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '{valid: 1'b0, src: SRC_NONE};
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage_q[i].valid;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; zero-cycle combinational grant, one grant per cycle.
// Read data returns RD_LATENCY cycles after grant; losers simply hold req until granted.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int RD_LATENCY    = 1,
  parameter int FAIR          = 0,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int                  STREAK_W   = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                last_ls_q, last_ls_d;
  logic                if_win, ls_win;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  arb_tag_t            tag_in, tag_out;
  logic                pipe_busy;
  logic                rv_if, rv_ls;

  // Conflict resolution: round-robin on last winner, or LS priority broken by the IF starvation limit.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!reset) begin
      if (bus.if_req && bus.ls_req) begin
        if (FAIR != 0) if_win = last_ls_q;
        else           if_win = (streak_q >= STREAK_MAX);
        ls_win = !if_win;
      end else begin
        if_win = bus.if_req;
        ls_win = bus.ls_req;
      end
    end
  end

  always_comb begin
    streak_d  = streak_q;
    last_ls_d = last_ls_q;
    if (if_win || !bus.if_req)           streak_d = '0;
    else if (ls_win && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
    if (if_win)      last_ls_d = 1'b0;
    else if (ls_win) last_ls_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q  <= '0;
      last_ls_q <= 1'b0;
    end else begin
      streak_q  <= streak_d;
      last_ls_q <= last_ls_d;
    end
  end

  always_comb begin
    addr_sel       = '0;
    wdata_sel      = '0;
    bus.mem_funct3 = 3'b000;
    bus.mem_wren   = 1'b0;
    tag_in         = '{valid: 1'b0, src: SRC_NONE};
    if (if_win) begin
      addr_sel       = bus.if_addr;
      bus.mem_funct3 = FUNCT3_WORD;
      tag_in         = '{valid: 1'b1, src: SRC_IF};
    end else if (ls_win) begin
      addr_sel       = bus.ls_addr;
      wdata_sel      = bus.ls_wdata;
      bus.mem_funct3 = bus.ls_funct3;
      bus.mem_wren   = bus.ls_we;
      if (!bus.ls_we) tag_in = '{valid: 1'b1, src: SRC_LS};
    end
  end

  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.if_gnt    = if_win;
  assign bus.ls_gnt    = ls_win;

  arb_resp_pipe #(.DEPTH(RD_LATENCY)) u_resp_pipe (
    .clk       (clk),
    .reset     (reset),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (pipe_busy)
  );

  // Gate with reset so a tag still sitting in the pipe cannot leak out during the reset cycle.
  assign rv_if = !reset && tag_out.valid && (tag_out.src == SRC_IF);
  assign rv_ls = !reset && tag_out.valid && (tag_out.src == SRC_LS);

  assign bus.if_rvalid = rv_if;
  assign bus.ls_rvalid = rv_ls;
  assign bus.if_rdata  = rv_if ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = rv_ls ? bus.mem_rdata : '0;
  assign bus.busy      = !reset && pipe_busy;

endmodule
